// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Control unit for a multicycle RV32I-style datapath.  Sequences every
// instruction through fetch, decode, execute, optional memory access and
// write-back, and drives the datapath strobes and mux selects.  It also
// watches memory handshakes for stalls and counts retired instructions.
//
// Parameters
//   MEM_TIMEOUT  wait cycles without mem_ack before mem_err pulses (1..255)
//   CNT_W        width of the retire counter
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   instr_op        IR opcode field, valid from DECODE onward
//   alu_zero        ALU take/compare flag for branches
//   mem_ack         memory handshake done (only used in FETCH and MEM)
//   mem_req/mem_we  memory request / write enable
//   mem_addr_sel    memory address mux: 0=PC, 1=ALU out
//   ir_we           instruction register load
//   alu_src_a       0=rs1, 1=PC
//   alu_src_b       0=rs2, 1=imm, 2=const 4
//   pc_we, pc_src   PC load and PC source: 0=PC+4, 1=ALU out, 2=PC+imm
//   reg_we, wb_sel  register write and write-back source: 0=ALU, 1=mem, 2=PC+4
//   state           current FSM state
//   retire          one-cycle pulse per completed instruction
//   retire_cnt      wrapping count of retire pulses
//   mem_err         one-cycle pulse when a memory wait times out
//   trap            sticky illegal-opcode flag
//
// Configuration
//   ILLEGAL_TRAP_EN  defined: unknown opcodes enter TRAP and set trap until
//                    reset.  Undefined (default): unknown opcodes retire as
//                    NOPs, trap is tied low and TRAP is unreachable.
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | request instruction at PC, load IR on mem_ack
// DECODE | one idle cycle while the register file/immediate settle
// EXEC   | drive ALU selects by opcode; branches and NOPs retire here
// MEM    | load/store access at ALU address, hold until mem_ack
// WB     | register write, PC update, retire
// TRAP   | illegal opcode seen, everything quiet until reset
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       instr_op,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             mem_err,
    output logic             trap
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_LUI,
        CLS_AUIPC,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_ILL
    } op_cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [7:0] TIMEOUT   = MEM_TIMEOUT[7:0];

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_ALU    = 2'd1;
    localparam logic [1:0] PC_IMM    = 2'd2;
    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_LINK   = 2'd2;

    state_t           state_q, state_d;
    logic             active_q, active_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    op_cls_t          cls_q, cls_d;
    logic [1:0]       link_src_q, link_src_d;
    logic             sel_a_q, sel_a_d;
    logic [1:0]       sel_b_q, sel_b_d;
    op_cls_t          op_cls;
`ifdef ILLEGAL_TRAP_EN
    logic             trap_q, trap_d;
`endif

    always_comb begin
        case (instr_op)
            OP_R:      op_cls = CLS_R;
            OP_I:      op_cls = CLS_I;
            OP_LOAD:   op_cls = CLS_LOAD;
            OP_STORE:  op_cls = CLS_STORE;
            OP_LUI:    op_cls = CLS_LUI;
            OP_AUIPC:  op_cls = CLS_AUIPC;
            OP_BRANCH: op_cls = CLS_BRANCH;
            OP_JAL:    op_cls = CLS_JAL;
            OP_JALR:   op_cls = CLS_JALR;
            default:   op_cls = CLS_ILL;
        endcase
    end

    // active_q stays low through reset and for the first edge after it, so
    // every output is quiet while rst_n is low (including mid-transaction)
    // and the request comes up cleanly on the first clock.
    always_comb begin
        state_d      = state_q;
        active_d     = 1'b1;
        cls_d        = cls_q;
        link_src_d   = link_src_q;
        sel_a_d      = sel_a_q;
        sel_b_d      = sel_b_q;
`ifdef ILLEGAL_TRAP_EN
        trap_d       = trap_q;
`endif
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_RS2;
        pc_we        = 1'b0;
        pc_src       = PC_PLUS4;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        retire       = 1'b0;
        mem_err      = 1'b0;

        if (active_q) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end
                end

                S_DECODE: begin
                    state_d = S_EXEC;
                end

                S_EXEC: begin
                    link_src_d = PC_PLUS4;
                    state_d    = S_WB;
                    case (op_cls)
                        CLS_R: ;
                        CLS_I, CLS_LUI: begin
                            alu_src_b = SRCB_IMM;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            alu_src_b = SRCB_IMM;
                            state_d   = S_MEM;
                        end
                        CLS_AUIPC: begin
                            alu_src_a = 1'b1;
                            alu_src_b = SRCB_IMM;
                        end
                        CLS_BRANCH: begin
                            pc_we   = 1'b1;
                            pc_src  = alu_zero ? PC_IMM : PC_PLUS4;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                        CLS_JAL: begin
                            link_src_d = PC_IMM;
                        end
                        CLS_JALR: begin
                            alu_src_b  = SRCB_IMM;
                            link_src_d = PC_ALU;
                        end
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            trap_d  = 1'b1;
                            state_d = S_TRAP;
`else
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
`endif
                        end
                    endcase
                    // MEM keeps presenting the address computation from EXEC
                    cls_d   = op_cls;
                    sel_a_d = alu_src_a;
                    sel_b_d = alu_src_b;
                end

                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (cls_q == CLS_STORE);
                    alu_src_a    = sel_a_q;
                    alu_src_b    = sel_b_q;
                    if (mem_ack) begin
                        if (cls_q == CLS_STORE) begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end

                S_WB: begin
                    reg_we  = 1'b1;
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    pc_src  = link_src_q;
                    state_d = S_FETCH;
                    if (cls_q == CLS_LOAD) begin
                        wb_sel = WB_MEM;
                    end else if (cls_q == CLS_JAL || cls_q == CLS_JALR) begin
                        wb_sel = WB_LINK;
                    end
                end

`ifdef ILLEGAL_TRAP_EN
                S_TRAP: ;
`endif

                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end

        // Stall watchdog: on timeout the request simply stays up (retry);
        // an ack arriving in the timeout cycle takes priority.
        wait_d = '0;
        if (mem_req && !mem_ack) begin
            if (wait_q == TIMEOUT) begin
                mem_err = 1'b1;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end
        if (state_d != state_q) begin
            wait_d = '0;
        end

        retire_cnt_d = retire_cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            active_q     <= 1'b0;
            wait_q       <= '0;
            retire_cnt_q <= '0;
            cls_q        <= CLS_R;
            link_src_q   <= PC_PLUS4;
            sel_a_q      <= 1'b0;
            sel_b_q      <= SRCB_RS2;
`ifdef ILLEGAL_TRAP_EN
            trap_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            wait_q       <= wait_d;
            retire_cnt_q <= retire_cnt_d;
            cls_q        <= cls_d;
            link_src_q   <= link_src_d;
            sel_a_q      <= sel_a_d;
            sel_b_q      <= sel_b_d;
`ifdef ILLEGAL_TRAP_EN
            trap_q       <= trap_d;
`endif
        end
    end

    assign state      = state_q;
    assign retire_cnt = retire_cnt_q;

`ifdef ILLEGAL_TRAP_EN
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int T  = 5;
    localparam int CW = 3;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    instr_op = 7'd0;
    logic          alu_zero = 1'b0;
    logic          mem_ack = 1'b0;
    logic          mem_req, mem_we, mem_addr_sel, ir_we, alu_src_a;
    logic [1:0]    alu_src_b, pc_src, wb_sel;
    logic          pc_we, reg_we, retire, mem_err, trap;
    logic [2:0]    state;
    logic [CW-1:0] retire_cnt;

    multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .instr_op(instr_op), .alu_zero(alu_zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .wb_sel(wb_sel), .state(state), .retire(retire), .retire_cnt(retire_cnt),
        .mem_err(mem_err), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_we;
        logic       a;
        logic [1:0] b;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       retire;
        logic       mem_err;
        logic       trap;
    } exp_t;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q = '0;
    bit   exp_valid = 1'b0;
    int   exp_cnt = 0;
    int   err_seen = 0;
    int   sel_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("state",        32'(state),        32'(exp_q.st));
            chk("mem_req",      32'(mem_req),      32'(exp_q.mem_req));
            chk("mem_we",       32'(mem_we),       32'(exp_q.mem_we));
            chk("mem_addr_sel", 32'(mem_addr_sel), 32'(exp_q.addr_sel));
            chk("ir_we",        32'(ir_we),        32'(exp_q.ir_we));
            chk("alu_src_a",    32'(alu_src_a),    32'(exp_q.a));
            chk("alu_src_b",    32'(alu_src_b),    32'(exp_q.b));
            chk("pc_we",        32'(pc_we),        32'(exp_q.pc_we));
            chk("pc_src",       32'(pc_src),       32'(exp_q.pc_src));
            chk("reg_we",       32'(reg_we),       32'(exp_q.reg_we));
            chk("wb_sel",       32'(wb_sel),       32'(exp_q.wb_sel));
            chk("retire",       32'(retire),       32'(exp_q.retire));
            chk("mem_err",      32'(mem_err),      32'(exp_q.mem_err));
            chk("trap",         32'(trap),         32'(exp_q.trap));
            chk("retire_cnt",   32'(retire_cnt),   32'(exp_cnt));
        end
    end

    always @(negedge clk) begin
        if (mem_err === 1'b1) err_seen++;
        if (mem_addr_sel === 1'b1) sel_cycles++;
    end

    // One clock cycle with the given expected outputs; inputs change 1 time
    // unit after the rising edge, outputs are compared on the falling edge.
    task automatic cyc(input exp_t e, input logic ack);
        mem_ack   = ack;
        exp_q     = e;
        exp_valid = 1'b1;
        @(posedge clk);
        if (e.retire) exp_cnt = (exp_cnt + 1) % (1 << CW);
        #1;
    endtask

    function automatic bit known_op(input logic [6:0] op);
        return op == OP_R || op == OP_I || op == OP_LD || op == OP_ST ||
               op == OP_LUI || op == OP_AUIPC || op == OP_BR ||
               op == OP_JAL || op == OP_JALR;
    endfunction

    // Timeout model: within one request, every (T+1)-th consecutive wait
    // cycle raises mem_err.
    function automatic logic err_at(input int k);
        return ((k + 1) % (T + 1)) == 0;
    endfunction

    task automatic do_reset();
        exp_valid = 1'b0;
        rst_n     = 1'b0;
        mem_ack   = 1'b1;
        #3;
        chk("rst_state",      32'(state),      32'd0);
        chk("rst_mem_req",    32'(mem_req),    32'd0);
        chk("rst_ir_we",      32'(ir_we),      32'd0);
        chk("rst_pc_we",      32'(pc_we),      32'd0);
        chk("rst_reg_we",     32'(reg_we),     32'd0);
        chk("rst_retire",     32'(retire),     32'd0);
        chk("rst_mem_err",    32'(mem_err),    32'd0);
        chk("rst_trap",       32'(trap),       32'd0);
        chk("rst_alu_src_b",  32'(alu_src_b),  32'd0);
        chk("rst_pc_src",     32'(pc_src),     32'd0);
        chk("rst_wb_sel",     32'(wb_sel),     32'd0);
        chk("rst_retire_cnt", 32'(retire_cnt), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n   = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic zero,
                             input int fw, input int mw, input bit abort);
        exp_t e;
        bit   is_mem;
        instr_op = 7'h7f;
        alu_zero = zero;
        for (int k = 0; k < fw; k++) begin
            e = '0; e.mem_req = 1'b1; e.mem_err = err_at(k);
            cyc(e, 1'b0);
        end
        e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1;
        cyc(e, 1'b1);

        instr_op = op;
        e = '0; e.st = 3'd1;
        cyc(e, 1'b1);

        e = '0; e.st = 3'd2;
        case (op)
            OP_I, OP_LD, OP_ST, OP_LUI, OP_JALR: e.b = 2'd1;
            OP_AUIPC: begin e.a = 1'b1; e.b = 2'd1; end
            OP_BR: begin
                e.pc_we = 1'b1; e.pc_src = zero ? 2'd2 : 2'd0; e.retire = 1'b1;
            end
            default: begin
`ifndef ILLEGAL_TRAP_EN
                if (!known_op(op)) begin e.pc_we = 1'b1; e.retire = 1'b1; end
`endif
            end
        endcase
        cyc(e, 1'b1);
        if (op == OP_BR) begin mem_ack = 1'b0; return; end
        if (!known_op(op)) begin
`ifdef ILLEGAL_TRAP_EN
            for (int k = 0; k < 10; k++) begin
                e = '0; e.st = 3'd5; e.trap = 1'b1;
                cyc(e, k[0]);
            end
`endif
            mem_ack = 1'b0;
            return;
        end

        is_mem = (op == OP_LD || op == OP_ST);
        if (is_mem) begin
            if (abort) begin
                exp_valid = 1'b0;
                #1;
                chk("abort_mem_req_before", 32'(mem_req), 32'd1);
                chk("abort_state_before",   32'(state),   32'd3);
                #1;
                rst_n = 1'b0;
                #1;
                chk("abort_mem_req",   32'(mem_req),      32'd0);
                chk("abort_mem_we",    32'(mem_we),       32'd0);
                chk("abort_addr_sel",  32'(mem_addr_sel), 32'd0);
                chk("abort_state",     32'(state),        32'd0);
                chk("abort_retire_cnt",32'(retire_cnt),   32'd0);
                exp_cnt = 0;
                mem_ack = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            for (int k = 0; k < mw; k++) begin
                e = '0; e.st = 3'd3; e.mem_req = 1'b1; e.addr_sel = 1'b1;
                e.mem_we = (op == OP_ST); e.b = 2'd1; e.mem_err = err_at(k);
                cyc(e, 1'b0);
            end
            e = '0; e.st = 3'd3; e.mem_req = 1'b1; e.addr_sel = 1'b1;
            e.mem_we = (op == OP_ST); e.b = 2'd1;
            if (op == OP_ST) begin e.pc_we = 1'b1; e.retire = 1'b1; end
            cyc(e, 1'b1);
            if (op == OP_ST) begin mem_ack = 1'b0; return; end
        end

        e = '0; e.st = 3'd4; e.reg_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
        if (op == OP_LD) e.wb_sel = 2'd1;
        else if (op == OP_JAL || op == OP_JALR) e.wb_sel = 2'd2;
        if (op == OP_JAL) e.pc_src = 2'd2;
        else if (op == OP_JALR) e.pc_src = 2'd1;
        cyc(e, 1'b1);
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        run_instr(OP_R, 1'b0, 0, 0, 1'b0);
        chk("lit_cnt_after_add", 32'(retire_cnt), 32'd1);

        sel_cycles = 0;
        run_instr(OP_LD, 1'b0, 0, 3, 1'b0);
        chk("lit_load_addr_sel_cycles", 32'(sel_cycles), 32'd4);

        err_seen = 0;
        run_instr(OP_I, 1'b1, 6, 0, 1'b0);
        chk("lit_fetch6_err_pulses", 32'(err_seen), 32'd1);

        run_instr(OP_BR, 1'b1, 0, 0, 1'b0);
        run_instr(OP_BR, 1'b0, 2, 0, 1'b0);
        run_instr(OP_JALR, 1'b0, 0, 0, 1'b0);
        run_instr(OP_JAL, 1'b1, 1, 0, 1'b0);
        run_instr(OP_ST, 1'b0, 0, 2, 1'b0);
        chk("lit_cnt_wrap", 32'(retire_cnt), 32'd0);

        run_instr(OP_LUI, 1'b0, 0, 0, 1'b0);
        run_instr(OP_AUIPC, 1'b1, 1, 0, 1'b0);

        err_seen = 0;
        run_instr(OP_LD, 1'b0, 5, 12, 1'b0);
        chk("lit_mem12_err_pulses", 32'(err_seen), 32'd2);
        chk("lit_cnt_after_11", 32'(retire_cnt), 32'd3);

        run_instr(7'b0000000, 1'b0, 0, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        chk("lit_trap_held", 32'(trap), 32'd1);
        chk("lit_trap_state", 32'(state), 32'd5);
        do_reset();
`else
        chk("lit_nop_cnt", 32'(retire_cnt), 32'd4);
        chk("lit_nop_state", 32'(state), 32'd0);
`endif

        run_instr(OP_LD, 1'b0, 1, 0, 1'b1);
        run_instr(OP_R, 1'b0, 0, 0, 1'b0);
        chk("lit_cnt_after_abort", 32'(retire_cnt), 32'd1);

        exp_valid = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
